seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter INS_ADDR_WIDTH, default 8, instruction-memory address width.
REQ-002 SHALL have parameter INS_WIDTH, default 64, instruction word width.
REQ-003 SHALL have parameter RD_LAT, default 1, instruction BRAM read latency in cycles (1..4).
REQ-004 SHALL have ports: clk  in  1  sole clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin program run; end_addr  in  INS_ADDR_WIDTH  last instruction address.
REQ-007 SHALL have ports: stall  in  1  datapath hold; abort  in  1  terminate run.
REQ-008 SHALL have ports: load_valid  in  1  host write request; load_addr  in  INS_ADDR_WIDTH  write address; load_data  in  INS_WIDTH  write data; load_ready  out  1  write accepted.
REQ-009 SHALL have ports: wea  out  1, addra  out  INS_ADDR_WIDTH, dina  out  INS_WIDTH  BRAM port A write.
REQ-010 SHALL have ports: pc  out  INS_ADDR_WIDTH  BRAM port B read address; ins_valid  out  1  BRAM doutb holds an issued instruction.
REQ-011 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-013 SHALL drive load_ready=1 only in IDLE, combinationally.
REQ-014 SHALL, on load_valid&load_ready, register wea=1, addra=load_addr, dina=load_data for exactly the next cycle; otherwise wea=0 and addra/dina hold.
REQ-015 SHALL, in IDLE with start=1 and load_valid=0, capture end_addr, set pc=0, enter RUN.
REQ-016 SHALL give load priority: start coinciding with accepted load is ignored (state stays IDLE).
REQ-017 SHALL, in RUN each cycle with stall=0, issue address pc and advance pc by 1; stall=1 holds pc and issues nothing.
REQ-018 SHALL, in RUN when pc==captured end_addr and stall=0, issue that address, hold pc, enter DRAIN; pc never wraps.
REQ-019 SHALL assert ins_valid exactly RD_LAT cycles after each issue, via an RD_LAT-deep shift register fed with the issue bit.
REQ-020 SHALL remain in DRAIN until the shift register is empty, then enter DONE.
REQ-021 SHALL assert done=1 for the single DONE cycle, then return to IDLE.
REQ-022 SHALL drive busy=1 in RUN and DRAIN, 0 otherwise.
REQ-023 SHALL, on abort in RUN or DRAIN, enter IDLE next cycle, clear the shift register, set pc=0, and not assert done; abort elsewhere is ignored.
REQ-024 SHALL issue exactly captured end_addr+1 instructions per uninterrupted run; end_addr=0 issues one.
REQ-025 SHALL ignore start while not in IDLE; end_addr changes after capture have no effect.

Reset
REQ-026 SHALL, while rstn=0 (asynchronous), force state IDLE, pc=0, wea=0, addra=0, dina=0, shift register 0, ins_valid=0, busy=0, done=0.
REQ-027 SHALL, on reset mid-run, discard the run without asserting done.

Verification
REQ-028 Load: load_valid with addr 5, data 0xDEAD_BEEF_0000_0001 in IDLE -> load_ready=1 same cycle, wea=1, addra=5, dina=value next cycle only.
REQ-029 Run: end_addr=3, start, no stall, RD_LAT=1 -> pc 0,1,2,3; ins_valid high 4 consecutive cycles starting one cycle after first issue; done pulses once; busy falls with DONE.
REQ-030 Stall: end_addr=2, stall for 2 cycles after first issue -> pc holds 1 for 2 cycles, ins_valid gap of 2, total 3 valids, done once.
REQ-031 Boundary: end_addr=255 (INS_ADDR_WIDTH=8) -> 256 issues, pc stops at 255, no wrap to 0; end_addr=0 -> one valid.
REQ-032 Abort/priority: abort two cycles into RUN -> IDLE next cycle, no done, no further ins_valid; start with load_valid in IDLE -> write performed, busy stays 0.
REQ-033 Reset: rstn low during DRAIN -> all outputs zero immediately, no done after rstn release.

Source files
------------

// File: rtl/seq_ctrl.sv
// Instruction sequencer: loads the instruction BRAM over port A, then walks
// port B from 0 to a captured end address and flags when each word is valid.
`timescale 1ns/1ps
module seq_ctrl #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int INS_WIDTH      = 64,
    parameter int RD_LAT         = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH-1:0] end_addr,
    input  logic                      stall,
    input  logic                      abort,
    input  logic                      load_valid,
    input  logic [INS_ADDR_WIDTH-1:0] load_addr,
    input  logic [INS_WIDTH-1:0]      load_data,
    output logic                      load_ready,
    output logic                      wea,
    output logic [INS_ADDR_WIDTH-1:0] addra,
    output logic [INS_WIDTH-1:0]      dina,
    output logic [INS_ADDR_WIDTH-1:0] pc,
    output logic                      ins_valid,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic [INS_ADDR_WIDTH-1:0] r_pc;
    logic [INS_ADDR_WIDTH-1:0] r_end;
    logic [RD_LAT-1:0]         r_vld_pipe;
    logic                      w_load;
    logic                      w_start;
    logic                      w_issue;
    logic                      w_abort;

    // load_ready is gated by rstn so every output reads zero while in reset
    assign load_ready = rstn && (r_state == S_IDLE);
    assign w_load     = load_valid && load_ready;
    assign w_start    = (r_state == S_IDLE) && start && !load_valid;
    assign w_abort    = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_issue    = (r_state == S_RUN) && !stall && !abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
        end else begin
            wea <= w_load;
            if (w_load) begin
                addra <= load_addr;
                dina  <= load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_end   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_end   <= end_addr;
                        r_pc    <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_pc    <= '0;
                        r_state <= S_IDLE;
                    end else if (!stall) begin
                        // last address is held rather than incremented, so pc never wraps
                        if (r_pc == r_end) r_state <= S_DRAIN;
                        else               r_pc    <= r_pc + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_pc    <= '0;
                        r_state <= S_IDLE;
                    end else if (r_vld_pipe == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Issue bit travels alongside the BRAM read so ins_valid lines up with doutb
    generate
        if (RD_LAT == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)        r_vld_pipe <= '0;
                else if (w_abort) r_vld_pipe <= '0;
                else              r_vld_pipe <= w_issue;
            end
        end else begin : g_pipeN
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)        r_vld_pipe <= '0;
                else if (w_abort) r_vld_pipe <= '0;
                else              r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], w_issue};
            end
        end
    endgenerate

    assign pc        = r_pc;
    assign ins_valid = r_vld_pipe[RD_LAT-1];
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl (8-bit addresses, 64-bit words, RD_LAT=1).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  end_addr;
    logic        stall;
    logic        abort;
    logic        load_valid;
    logic [7:0]  load_addr;
    logic [63:0] load_data;
    logic        load_ready;
    logic        wea;
    logic [7:0]  addra;
    logic [63:0] dina;
    logic [7:0]  pc;
    logic        ins_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_ctrl #(.INS_ADDR_WIDTH(8), .INS_WIDTH(64), .RD_LAT(1)) dut (
        .clk(clk), .rstn(rstn), .start(start), .end_addr(end_addr),
        .stall(stall), .abort(abort), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
        .wea(wea), .addra(addra), .dina(dina), .pc(pc),
        .ins_valid(ins_valid), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run, changes end_addr after capture, then counts valids/dones
    // until done (bounded) plus a few trailing cycles for stray pulses.
    task automatic run_prog(input logic [7:0] ea, output int nv, output int nd,
                            output logic [7:0] pc_at_done, output bit wrapped,
                            output bit timeout);
        logic [7:0] prev;
        nv = 0; nd = 0; prev = '0; wrapped = 0; timeout = 1; pc_at_done = '0;
        @(negedge clk);
        start = 1'b1; end_addr = ea;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0;
                end_addr = ~ea;
            end
            if (ins_valid) nv++;
            if (busy && (pc < prev)) wrapped = 1;
            prev = pc;
            if (done) begin
                nd++;
                pc_at_done = pc;
                timeout = 0;
                break;
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ins_valid) nv++;
            if (done) nd++;
        end
    endtask

    logic [7:0] r_pc_e   [8];
    logic       r_iv_e   [8];
    logic       r_busy_e [8];
    logic       r_done_e [8];
    logic [7:0] s_pc_e   [9];
    logic       s_iv_e   [9];
    logic       s_busy_e [9];
    logic       s_done_e [9];
    logic       s_stall  [9];

    int         nv, nd;
    logic [7:0] pcd;
    bit         wr, to;

    initial begin
        rstn = 1'b0; start = 1'b0; end_addr = '0; stall = 1'b0; abort = 1'b0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;

        // reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wea", 64'(wea), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_iv", 64'(ins_valid), 64'd0);
        chk("rst_addra", 64'(addra), 64'd0);
        chk("rst_dina", dina, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // host load
        load_valid = 1'b1; load_addr = 8'd5; load_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("ld_ready", 64'(load_ready), 64'd1);
        chk("ld_wea_same", 64'(wea), 64'd0);
        @(negedge clk);
        chk("ld_wea", 64'(wea), 64'd1);
        chk("ld_addra", 64'(addra), 64'd5);
        chk("ld_dina", dina, 64'hDEAD_BEEF_0000_0001);
        load_valid = 1'b0; load_addr = 8'd9; load_data = 64'h1234;
        @(negedge clk);
        chk("ld_wea_off", 64'(wea), 64'd0);
        chk("ld_addra_hold", 64'(addra), 64'd5);
        chk("ld_dina_hold", dina, 64'hDEAD_BEEF_0000_0001);

        // run end_addr=3, cycle by cycle
        r_pc_e   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        r_iv_e   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        r_busy_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        r_done_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        start = 1'b1; end_addr = 8'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            chk($sformatf("run_pc[%0d]", i), 64'(pc), 64'(r_pc_e[i]));
            chk($sformatf("run_iv[%0d]", i), 64'(ins_valid), 64'(r_iv_e[i]));
            chk($sformatf("run_busy[%0d]", i), 64'(busy), 64'(r_busy_e[i]));
            chk($sformatf("run_done[%0d]", i), 64'(done), 64'(r_done_e[i]));
        end

        // stall two cycles after first issue, end_addr=2
        s_pc_e   = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
        s_iv_e   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s_busy_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s_done_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        s_stall  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        start = 1'b1; end_addr = 8'd2;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            chk($sformatf("stl_pc[%0d]", i), 64'(pc), 64'(s_pc_e[i]));
            chk($sformatf("stl_iv[%0d]", i), 64'(ins_valid), 64'(s_iv_e[i]));
            chk($sformatf("stl_busy[%0d]", i), 64'(busy), 64'(s_busy_e[i]));
            chk($sformatf("stl_done[%0d]", i), 64'(done), 64'(s_done_e[i]));
            stall = s_stall[i];
        end

        // boundaries: full address space, then a single instruction
        run_prog(8'd255, nv, nd, pcd, wr, to);
        chk("b255_timeout", 64'(to), 64'd0);
        chk("b255_valids", 64'(nv), 64'd256);
        chk("b255_dones", 64'(nd), 64'd1);
        chk("b255_pc", 64'(pcd), 64'd255);
        chk("b255_wrap", 64'(wr), 64'd0);
        run_prog(8'd0, nv, nd, pcd, wr, to);
        chk("b0_timeout", 64'(to), 64'd0);
        chk("b0_valids", 64'(nv), 64'd1);
        chk("b0_dones", 64'(nd), 64'd1);

        // abort two cycles into RUN
        @(negedge clk);
        start = 1'b1; end_addr = 8'd10;
        @(negedge clk);
        start = 1'b0;
        chk("ab_busy_pre", 64'(busy), 64'd1);
        @(negedge clk);
        chk("ab_pc_pre", 64'(pc), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_pc", 64'(pc), 64'd0);
        chk("ab_iv", 64'(ins_valid), 64'd0);
        nv = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ins_valid) nv++;
            if (done) nd++;
        end
        chk("ab_valids", 64'(nv), 64'd0);
        chk("ab_dones", 64'(nd), 64'd0);

        // start alongside a load: load wins, run never starts
        load_valid = 1'b1; start = 1'b1; end_addr = 8'd4;
        load_addr = 8'd7; load_data = 64'hCAFE;
        @(negedge clk);
        load_valid = 1'b0; start = 1'b0;
        chk("pri_wea", 64'(wea), 64'd1);
        chk("pri_addra", 64'(addra), 64'd7);
        chk("pri_dina", dina, 64'hCAFE);
        chk("pri_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("pri_busy2", 64'(busy), 64'd0);
        chk("pri_ready", 64'(load_ready), 64'd1);

        // reset asserted during DRAIN
        start = 1'b1; end_addr = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_busy_pre", 64'(busy), 64'd1);
        chk("rd_iv_pre", 64'(ins_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rd_busy", 64'(busy), 64'd0);
        chk("rd_iv", 64'(ins_valid), 64'd0);
        chk("rd_pc", 64'(pc), 64'd0);
        chk("rd_done", 64'(done), 64'd0);
        chk("rd_wea", 64'(wea), 64'd0);
        chk("rd_addra", 64'(addra), 64'd0);
        chk("rd_dina", dina, 64'd0);
        chk("rd_ready", 64'(load_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        nv = 0; nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ins_valid) nv++;
            if (done) nd++;
        end
        chk("rd_post_dones", 64'(nd), 64'd0);
        chk("rd_post_valids", 64'(nv), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
